// File: rtl/exp_arbiter.sv
// Packet-granular round-robin arbiter that shares one exp unit between NUM_PORTS
// streams and routes each result back with the id of the port that sent it.
//
//   state | meaning
//   IDLE  | no owner; pick the next requester after last_grant, all s_tready low
//   BUSY  | grant owns the exp unit until its tlast (or a forced release) is accepted
module exp_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_PORTS   = 4,
  parameter int EXP_LATENCY = 1,
  parameter int MAX_BEATS   = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           exp_in_tdata,
  output logic                            exp_in_tvalid,
  output logic                            exp_in_tlast,
  input  logic [DATA_WIDTH-1:0]           exp_out_tdata,
  input  logic                            exp_out_tvalid,
  input  logic                            exp_out_tlast,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic [$clog2(NUM_PORTS)-1:0]    m_tdest,
  output logic                            overrun_err
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [NUM_PORTS-1:0]    s_tready_q, s_tready_d;
  logic                    overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]   exp_in_tdata_q, exp_in_tdata_d;
  logic                    exp_in_tvalid_q, exp_in_tvalid_d;
  logic                    exp_in_tlast_q, exp_in_tlast_d;
  logic [GW-1:0]           exp_in_tag_q, exp_in_tag_d;
  logic [GW-1:0]           tag_pipe_q [EXP_LATENCY];
  logic [GW-1:0]           tag_pipe_d [EXP_LATENCY];
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [GW-1:0]           m_tdest_q, m_tdest_d;

  logic [GW-1:0]           pick;
  logic                    any_req;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    accept;
  logic                    forced;
  logic                    pkt_end;

  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    pick    = last_grant_q;
    any_req = |s_tvalid;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (s_tvalid[(int'(last_grant_q) + k) % NUM_PORTS]) begin
        pick = GW'((int'(last_grant_q) + k) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    sel_data  = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_valid = s_tvalid[grant_q];
    sel_last  = s_tlast[grant_q];
    accept    = (state_q == BUSY) && s_tready_q[grant_q] && sel_valid;
    forced    = accept && !sel_last && (beat_cnt_q == CW'(MAX_BEATS - 1));
    pkt_end   = accept && (sel_last || forced);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    s_tready_d   = s_tready_q;
    overrun_d    = overrun_q | forced;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = BUSY;
          grant_d    = pick;
          beat_cnt_d = '0;
          s_tready_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick;
        end
      end
      BUSY: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
        if (pkt_end) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          s_tready_d   = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        s_tready_d = '0;
      end
    endcase
  end

  // A forced release still marks the beat as tlast so the exp unit sees a closed packet.
  always_comb begin
    exp_in_tvalid_d = accept;
    exp_in_tlast_d  = pkt_end;
    exp_in_tdata_d  = accept ? sel_data : exp_in_tdata_q;
    exp_in_tag_d    = accept ? grant_q  : exp_in_tag_q;

    tag_pipe_d[0] = exp_in_tag_q;
    for (int i = 1; i < EXP_LATENCY; i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    m_tvalid_d = exp_out_tvalid;
    m_tlast_d  = exp_out_tvalid & exp_out_tlast;
    m_tdata_d  = exp_out_tvalid ? exp_out_tdata : m_tdata_q;
    m_tdest_d  = exp_out_tvalid ? tag_pipe_q[EXP_LATENCY-1] : m_tdest_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      last_grant_q    <= GW'(NUM_PORTS - 1);
      beat_cnt_q      <= '0;
      s_tready_q      <= '0;
      overrun_q       <= 1'b0;
      exp_in_tdata_q  <= '0;
      exp_in_tvalid_q <= 1'b0;
      exp_in_tlast_q  <= 1'b0;
      exp_in_tag_q    <= '0;
      for (int i = 0; i < EXP_LATENCY; i++) begin
        tag_pipe_q[i] <= '0;
      end
      m_tdata_q       <= '0;
      m_tvalid_q      <= 1'b0;
      m_tlast_q       <= 1'b0;
      m_tdest_q       <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      beat_cnt_q      <= beat_cnt_d;
      s_tready_q      <= s_tready_d;
      overrun_q       <= overrun_d;
      exp_in_tdata_q  <= exp_in_tdata_d;
      exp_in_tvalid_q <= exp_in_tvalid_d;
      exp_in_tlast_q  <= exp_in_tlast_d;
      exp_in_tag_q    <= exp_in_tag_d;
      for (int i = 0; i < EXP_LATENCY; i++) begin
        tag_pipe_q[i] <= tag_pipe_d[i];
      end
      m_tdata_q       <= m_tdata_d;
      m_tvalid_q      <= m_tvalid_d;
      m_tlast_q       <= m_tlast_d;
      m_tdest_q       <= m_tdest_d;
    end
  end

  assign s_tready      = s_tready_q;
  assign exp_in_tdata  = exp_in_tdata_q;
  assign exp_in_tvalid = exp_in_tvalid_q;
  assign exp_in_tlast  = exp_in_tlast_q;
  assign m_tdata       = m_tdata_q;
  assign m_tvalid      = m_tvalid_q;
  assign m_tlast       = m_tlast_q;
  assign m_tdest       = m_tdest_q;
  assign overrun_err   = overrun_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Bench for exp_arbiter: queue-driven requesters, a rounded-exp model of the shared
// unit, and a scoreboard checking data, destination, tlast and latency of every result.
module tb_exp_arbiter;
  localparam int DW = 16;
  localparam int NP = 4;
  localparam int L  = 1;
  localparam int MB = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic [NP-1:0]    s_tlast = '0;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    exp_in_tdata;
  logic             exp_in_tvalid, exp_in_tlast;
  logic [DW-1:0]    exp_out_tdata;
  logic             exp_out_tvalid, exp_out_tlast;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tlast;
  logic [GW-1:0]    m_tdest;
  logic             overrun_err;

  exp_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .EXP_LATENCY(L), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .exp_in_tdata(exp_in_tdata), .exp_in_tvalid(exp_in_tvalid), .exp_in_tlast(exp_in_tlast),
    .exp_out_tdata(exp_out_tdata), .exp_out_tvalid(exp_out_tvalid), .exp_out_tlast(exp_out_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdest(m_tdest),
    .overrun_err(overrun_err)
  );

  function automatic logic [DW-1:0] exp_tab(input logic [DW-1:0] x);
    case (x)
      16'd0:   return 16'd1;
      16'd1:   return 16'd3;
      16'd2:   return 16'd7;
      16'd3:   return 16'd20;
      16'd4:   return 16'd55;
      16'd5:   return 16'd148;
      16'd6:   return 16'd403;
      16'd7:   return 16'd1097;
      16'd8:   return 16'd2981;
      16'd9:   return 16'd8103;
      16'd10:  return 16'd22026;
      default: return 16'hFFFF;
    endcase
  endfunction

  // shared exp unit model, reset together with the arbiter
  logic [DW-1:0] eu_d [L];
  logic          eu_v [L];
  logic          eu_l [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin eu_d[i] <= '0; eu_v[i] <= 1'b0; eu_l[i] <= 1'b0; end
    end else begin
      eu_d[0] <= exp_tab(exp_in_tdata);
      eu_v[0] <= exp_in_tvalid;
      eu_l[0] <= exp_in_tlast;
      for (int i = 1; i < L; i++) begin
        eu_d[i] <= eu_d[i-1]; eu_v[i] <= eu_v[i-1]; eu_l[i] <= eu_l[i-1];
      end
    end
  end
  assign exp_out_tdata  = eu_d[L-1];
  assign exp_out_tvalid = eu_v[L-1];
  assign exp_out_tlast  = eu_l[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic v; logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [DW-1:0] d; int dest; logic l; int cyc; } exp_t;

  beat_t src_q [NP][$];
  exp_t  sb[$];
  logic  acc [NP];
  logic  shown [NP];
  int    bc [NP];
  logic  ovr_exp = 1'b0;
  int    grant_log[$];
  int    acc_cyc_log[$];
  int    out_d[$];
  int    out_dest[$];
  int    out_l[$];
  int    out_cyc[$];
  int    ein_cnt = 0;
  int    checks = 0;
  int    failures = 0;

  // requester driver: bubbles last one cycle, real beats stay until accepted
  initial begin
    for (int i = 0; i < NP; i++) begin acc[i] = 1'b0; shown[i] = 1'b0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
        if (rst) begin
          shown[i] = 1'b0; acc[i] = 1'b0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
        end else begin
          if (shown[i] && src_q[i].size() > 0) begin
            if (!src_q[i][0].v || acc[i]) void'(src_q[i].pop_front());
          end
          acc[i] = 1'b0;
          if (src_q[i].size() > 0) begin
            s_tvalid[i] = src_q[i][0].v;
            s_tlast[i]  = src_q[i][0].l;
            s_tdata[i*DW +: DW] = src_q[i][0].d;
            shown[i] = 1'b1;
          end else begin
            s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; shown[i] = 1'b0;
          end
        end
      end
    end
  end

  // monitor and scoreboard
  initial begin
    exp_t e;
    logic fcd;
    for (int i = 0; i < NP; i++) bc[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NP; i++) bc[i] = 0;
        ovr_exp = 1'b0;
        sb.delete();
      end else begin
        if (m_tvalid) begin
          out_d.push_back(int'(m_tdata)); out_dest.push_back(int'(m_tdest));
          out_l.push_back(int'(m_tlast)); out_cyc.push_back(cyc);
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got d=%0d dest=%0d with nothing outstanding", m_tdata, m_tdest);
          end else begin
            e = sb.pop_front();
            if (m_tdata !== e.d || int'(m_tdest) != e.dest || m_tlast !== e.l || (cyc - e.cyc) != L + 2) begin
              failures++;
              $display("FAIL sb_beat got d=%0d dest=%0d last=%0b lat=%0d exp d=%0d dest=%0d last=%0b lat=%0d",
                       m_tdata, m_tdest, m_tlast, cyc - e.cyc, e.d, e.dest, e.l, L + 2);
            end
          end
        end
        checks++;
        if (!$onehot0(s_tready)) begin
          failures++;
          $display("FAIL ready_onehot got=%b exp one-hot or zero", s_tready);
        end
        if (exp_in_tvalid) ein_cnt++;
        for (int i = 0; i < NP; i++) begin
          if (s_tvalid[i] && s_tready[i]) begin
            acc[i] = 1'b1;
            bc[i]++;
            fcd = (bc[i] == MB) && !s_tlast[i];
            e.d = exp_tab(s_tdata[i*DW +: DW]); e.dest = i; e.l = s_tlast[i] | fcd; e.cyc = cyc;
            sb.push_back(e);
            if (s_tlast[i] || fcd) bc[i] = 0;
            if (fcd) ovr_exp = 1'b1;
            grant_log.push_back(i);
            acc_cyc_log.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit src_empty();
    for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_beat(input int p, input logic v, input int d, input logic l);
    beat_t b;
    b.v = v; b.d = DW'(d); b.l = l;
    src_q[p].push_back(b);
  endtask

  task automatic clear_logs();
    grant_log.delete(); acc_cyc_log.delete();
    out_d.delete(); out_dest.delete(); out_l.delete(); out_cyc.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(src_empty() && sb.size() == 0) && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout got=%0d cycles exp below %0d", name, n, budget);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_tready !== '0) begin failures++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
    checks++; if (exp_in_tvalid !== 1'b0 || exp_in_tlast !== 1'b0) begin failures++; $display("FAIL rst_exp_in got v=%b l=%b exp 0", exp_in_tvalid, exp_in_tlast); end
    checks++; if (exp_in_tdata !== '0) begin failures++; $display("FAIL rst_exp_data got=%0d exp=0", exp_in_tdata); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_ctl got v=%b l=%b exp 0", m_tvalid, m_tlast); end
    checks++; if (m_tdata !== '0 || m_tdest !== '0) begin failures++; $display("FAIL rst_m_data got d=%0d dest=%0d exp 0", m_tdata, m_tdest); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun_err); end
    @(posedge clk); #2 rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_single_packet();
    int ed [3];
    ed = '{3, 20, 148};
    clear_logs();
    add_beat(0, 1, 1, 0); add_beat(0, 1, 3, 0); add_beat(0, 1, 5, 1);
    wait_idle("single", 60);
    checks++;
    if (grant_log.size() != 3 || out_d.size() != 3) begin
      failures++; $display("FAIL single_count got acc=%0d out=%0d exp 3", grant_log.size(), out_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_d[i] != ed[i] || out_dest[i] != 0 || out_l[i] != (i == 2 ? 1 : 0)) begin
          failures++; $display("FAIL single_out%0d got d=%0d dest=%0d l=%0d exp d=%0d dest=0", i, out_d[i], out_dest[i], out_l[i], ed[i]);
        end
      end
      checks++;
      if (out_cyc[0] - acc_cyc_log[0] != 3) begin
        failures++; $display("FAIL single_latency got=%0d exp=3", out_cyc[0] - acc_cyc_log[0]);
      end
      checks++;
      if (acc_cyc_log[2] - acc_cyc_log[0] != 2) begin
        failures++; $display("FAIL single_throughput got=%0d exp=2", acc_cyc_log[2] - acc_cyc_log[0]);
      end
    end
  endtask

  task automatic test_two_ports();
    int eg [4];
    eg = '{1, 1, 2, 2};
    pulse_reset();
    add_beat(1, 1, 2, 0); add_beat(1, 1, 4, 1);
    add_beat(2, 1, 6, 0); add_beat(2, 1, 7, 1);
    wait_idle("two_ports", 80);
    checks++;
    if (grant_log.size() != 4 || out_dest.size() != 4) begin
      failures++; $display("FAIL two_count got acc=%0d out=%0d exp 4", grant_log.size(), out_dest.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != eg[i] || out_dest[i] != eg[i]) begin
          failures++; $display("FAIL two_order%0d got grant=%0d dest=%0d exp=%0d", i, grant_log[i], out_dest[i], eg[i]);
        end
      end
      checks++;
      if (acc_cyc_log[2] - acc_cyc_log[1] != 2) begin
        failures++; $display("FAIL two_idle_gap got=%0d exp=2", acc_cyc_log[2] - acc_cyc_log[1]);
      end
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_beat(p, 1, p + 4 * r, 1);
    wait_idle("rr", 120);
    checks++;
    if (grant_log.size() != 8) begin
      failures++; $display("FAIL rr_count got=%0d exp=8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (grant_log[i] != i % NP || (i > 0 && acc_cyc_log[i] - acc_cyc_log[i-1] != 2)) begin
          failures++; $display("FAIL rr_grant%0d got port=%0d exp=%0d", i, grant_log[i], i % NP);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int el [6];
    el = '{0, 0, 0, 1, 0, 1};
    clear_logs();
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun_err); end
    for (int i = 0; i < 6; i++) add_beat(3, 1, i, i == 5);
    wait_idle("overrun", 100);
    checks++; if (overrun_err !== 1'b1 || ovr_exp !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
    checks++;
    if (grant_log.size() != 6 || out_l.size() != 6) begin
      failures++; $display("FAIL ovr_count got acc=%0d out=%0d exp 6", grant_log.size(), out_l.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_l[i] != el[i] || grant_log[i] != 3) begin
          failures++; $display("FAIL ovr_beat%0d got last=%0d port=%0d exp last=%0d port=3", i, out_l[i], grant_log[i], el[i]);
        end
      end
      checks++;
      if (acc_cyc_log[4] - acc_cyc_log[3] != 2) begin
        failures++; $display("FAIL ovr_regrant_gap got=%0d exp=2", acc_cyc_log[4] - acc_cyc_log[3]);
      end
    end
  endtask

  task automatic test_stall();
    int eg [5];
    int ein0;
    eg = '{2, 2, 2, 2, 0};
    clear_logs();
    ein0 = ein_cnt;
    add_beat(2, 1, 1, 0); add_beat(2, 1, 2, 0);
    add_beat(2, 0, 0, 0); add_beat(2, 0, 0, 0); add_beat(2, 0, 0, 0);
    add_beat(2, 1, 3, 0); add_beat(2, 1, 4, 1);
    add_beat(0, 0, 0, 0); add_beat(0, 1, 9, 1);
    wait_idle("stall", 100);
    checks++;
    if (grant_log.size() != 5) begin
      failures++; $display("FAIL stall_count got=%0d exp=5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] != eg[i]) begin
          failures++; $display("FAIL stall_order%0d got=%0d exp=%0d", i, grant_log[i], eg[i]);
        end
      end
      checks++;
      if (acc_cyc_log[2] - acc_cyc_log[1] != 4) begin
        failures++; $display("FAIL stall_gap got=%0d exp=4", acc_cyc_log[2] - acc_cyc_log[1]);
      end
    end
    checks++; if (ein_cnt - ein0 != 5) begin failures++; $display("FAIL stall_exp_in_beats got=%0d exp=5", ein_cnt - ein0); end
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL stall_sticky got=%b exp=1", overrun_err); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    add_beat(1, 1, 0, 1);
    for (int i = 1; i <= 4; i++) add_beat(2, 1, i, i == 4);
    while (grant_log.size() < 2 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n >= 40) begin failures++; $display("FAIL mid_timeout got=%0d cycles exp below 40", n); end
    @(posedge clk); #2 rst = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    @(posedge clk); @(negedge clk);
    checks++; if (s_tready !== '0) begin failures++; $display("FAIL mid_tready got=%b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_mvalid got=%b exp=0", m_tvalid); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL mid_overrun got=%b exp=0", overrun_err); end
    @(posedge clk); #2 rst = 1'b0;
    clear_logs();
    add_beat(2, 1, 5, 0); add_beat(2, 1, 6, 1);
    add_beat(0, 1, 8, 1);
    wait_idle("mid_after", 80);
    checks++;
    if (grant_log.size() != 3) begin
      failures++; $display("FAIL mid_count got=%0d exp=3", grant_log.size());
    end else if (grant_log[0] != 0 || grant_log[1] != 2) begin
      failures++; $display("FAIL mid_first got=%0d,%0d exp=0,2", grant_log[0], grant_log[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_two_ports();
    test_round_robin();
    test_overrun();
    test_stall();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
